// File: rtl/bask_pkg.sv
// Shared BASK link definitions: receiver FSM states, default bit period and frame levels.
package bask_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Also used by the modulator, so both ends of the link agree on the bit period.
    localparam int BIT_CYCLES_DEF = 25000;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/bask_bit_voter.sv
// Envelope synchronizer, rising-edge detector and mid-bit majority voter.
module bask_bit_voter
    import bask_pkg::*;
#(
    parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
    parameter int WIN         = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = $clog2(BIT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          env_in,
    input  logic          active,
    input  logic [CW-1:0] cyc,
    output logic          rise,
    output logic          vote_stb,
    output logic          vote_bit
);

    localparam int OW = $clog2(WIN) + 1;
    localparam logic [CW-1:0] WIN_LO = CW'(BIT_CYCLES / 2 - WIN / 2);
    localparam logic [CW-1:0] WIN_HI = CW'(BIT_CYCLES / 2 + WIN / 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   env_s;
    logic                   env_s_d;
    logic [OW-1:0]          ones;
    logic                   in_win;

    assign env_s    = sync_q[SYNC_STAGES-1];
    assign rise     = env_s & ~env_s_d;
    assign in_win   = active && (cyc >= WIN_LO) && (cyc < WIN_HI);
    assign vote_stb = active && (cyc == WIN_HI);
    // A tie (exactly half the window high) votes 0.
    assign vote_bit = ones > OW'(WIN / 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            env_s_d <= 1'b0;
            ones    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts one stage per clock.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], env_in};
            env_s_d <= env_s;
            if (!active || vote_stb) begin
                ones <= '0;
            end else if (in_win && env_s) begin
                ones <= ones + OW'(1);
            end
        end
    end

endmodule

// File: rtl/bask_env_demod_rx.sv
// BASK receive stage: frames voted envelope bits (start 1, 8 data MSB-first, stop 0) into bytes.
module bask_env_demod_rx
    import bask_pkg::*;
#(
    parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
    parameter int WIN         = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 env_in,
    output logic                 demod_bit,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

    rx_state_t              state;
    logic [CW-1:0]          cyc;
    logic [BW-1:0]          bidx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   rise;
    logic                   vote_stb;
    logic                   vote_bit;
    logic                   cyc_wrap;

    assign busy     = (state != IDLE);
    assign cyc_wrap = (cyc == CYC_LAST);

    bask_bit_voter #(
        .BIT_CYCLES  (BIT_CYCLES),
        .WIN         (WIN),
        .SYNC_STAGES (SYNC_STAGES),
        .CW          (CW)
    ) u_voter (
        .clk      (clk),
        .rst      (rst),
        .env_in   (env_in),
        .active   (busy),
        .cyc      (cyc),
        .rise     (rise),
        .vote_stb (vote_stb),
        .vote_bit (vote_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cyc        <= '0;
            bidx       <= '0;
            shreg      <= '0;
            demod_bit  <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || cyc_wrap) begin
                cyc <= '0;
            end else begin
                cyc <= cyc + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= START;
                    end
                end
                // A bad start vote leaves immediately, so reaching the wrap here means the start bit was good;
                // DATA is entered on the bit boundary so bidx always names the bit of the current period.
                START: begin
                    if (vote_stb) begin
                        demod_bit <= vote_bit;
                        if (vote_bit != START_LVL) begin
                            state <= IDLE;
                        end
                    end else if (cyc_wrap) begin
                        state <= DATA;
                        bidx  <= '0;
                    end
                end
                DATA: begin
                    if (vote_stb) begin
                        demod_bit <= vote_bit;
                        shreg     <= {shreg[DATA_BITS-2:0], vote_bit};
                    end
                    if (cyc_wrap) begin
                        if (bidx == BIDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bidx <= bidx + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (vote_stb) begin
                        demod_bit <= vote_bit;
                        state     <= IDLE;
                        if (vote_bit == STOP_LVL) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bask_env_demod_rx.sv
// Self-checking bench for bask_env_demod_rx with a shortened bit period.
module tb_bask_env_demod_rx;

    localparam int BC     = 200;
    localparam int WIN    = 64;
    localparam int SYNC   = 2;
    localparam int WIN_HI = BC / 2 + WIN / 2;
    localparam int LAT    = 9 * BC + WIN_HI + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       env_in;
    logic       demod_bit;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pc = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;
    int bv_pc = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    bask_env_demod_rx #(
        .BIT_CYCLES  (BC),
        .WIN         (WIN),
        .SYNC_STAGES (SYNC),
        .DATA_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .env_in     (env_in),
        .demod_bit  (demod_bit),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always @(posedge clk) pc++;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            bv_cnt++;
            bv_pc = pc;
            rx_q.push_back(rx_byte);
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // Transmitter model: start, data MSB first, stop, BC clk per bit; optional short
    // inverted pulses placed well inside each vote window.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                              input bit noisy, input bit chk_demod);
        logic [9:0] bits;
        bits = {1'b1, data, stop_lvl};
        for (int k = 0; k < 10; k++) begin
            logic b;
            int ns;
            int nl;
            b  = bits[9-k];
            ns = int'($urandom_range(100, 75));
            nl = int'($urandom_range(25, 5));
            for (int t = 0; t < BC; t++) begin
                env_in = (noisy && t >= ns && t < ns + nl) ? ~b : b;
                @(negedge clk);
            end
            if (chk_demod) begin
                checks++;
                if (demod_bit !== b) begin
                    errors++;
                    $display("FAIL demod_bit bit%0d of %h: got %b want %b", k, data, demod_bit, b);
                end
            end
        end
        env_in = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        env_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({demod_bit, rx_byte, byte_valid, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 000", {demod_bit, rx_byte, byte_valid, frame_err, busy});
        end
        rst = 1'b0;
        bv_cnt = 0; fe_cnt = 0; busy_cnt = 0;
        repeat (2000) @(negedge clk);
        checks++;
        if (bv_cnt + fe_cnt + busy_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: valid %0d err %0d busy %0d want 0", bv_cnt, fe_cnt, busy_cnt);
        end
        checks++;
        if ({demod_bit, rx_byte} !== 9'h000) begin
            errors++;
            $display("FAIL reset_hold: got %h want 000", {demod_bit, rx_byte});
        end
    endtask

    task automatic test_good_frame();
        int n0;
        int bv0;
        bv0 = bv_cnt;
        n0  = pc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (bv_cnt - bv0 !== 1) begin
            errors++;
            $display("FAIL good_count: got %0d want 1", bv_cnt - bv0);
        end
        checks++;
        if (rx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL good_byte: got %h want a5", rx_byte);
        end
        checks++;
        if (bv_pc - n0 !== LAT + 3) begin
            errors++;
            $display("FAIL good_latency: got %0d want %0d", bv_pc - n0, LAT + 3);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL good_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_glitch();
        int bv0;
        int fe0;
        bv0 = bv_cnt; fe0 = fe_cnt; busy_cnt = 0;
        env_in = 1'b1;
        repeat (20) @(negedge clk);
        env_in = 1'b0;
        repeat (400) @(negedge clk);
        checks++;
        if (busy_cnt !== WIN_HI + 1) begin
            errors++;
            $display("FAIL glitch_busy_len: got %0d want %0d", busy_cnt, WIN_HI + 1);
        end
        checks++;
        if (bv_cnt - bv0 + fe_cnt - fe0 !== 0) begin
            errors++;
            $display("FAIL glitch_pulse: valid %0d err %0d want 0", bv_cnt - bv0, fe_cnt - fe0);
        end
        checks++;
        if (busy !== 1'b0 || demod_bit !== 1'b0) begin
            errors++;
            $display("FAIL glitch_state: busy %b demod %b want 0 0", busy, demod_bit);
        end
    endtask

    task automatic test_bad_stop();
        int bv0;
        int fe0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        bv0 = bv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (50) @(negedge clk);
        checks++;
        if (fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL badstop_err: got %0d want 1", fe_cnt - fe0);
        end
        checks++;
        if (bv_cnt - bv0 !== 0) begin
            errors++;
            $display("FAIL badstop_valid: got %0d want 0", bv_cnt - bv0);
        end
        checks++;
        if (rx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL badstop_byte: got %h want a5", rx_byte);
        end
    endtask

    task automatic test_noise();
        int bv0;
        bv0 = bv_cnt;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (bv_cnt - bv0 !== 1 || rx_byte !== 8'h5A) begin
            errors++;
            $display("FAIL noise_byte: got %h x%0d want 5a x1", rx_byte, bv_cnt - bv0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b0, (i % 2) == 1, 1'b1);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rx_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        int bv0;
        int fe0;
        bits = {1'b1, 8'hFF, 1'b0};
        bv0 = bv_cnt; fe0 = fe_cnt;
        for (int k = 0; k < 5; k++) begin
            env_in = bits[9-k];
            repeat (BC) @(negedge clk);
        end
        env_in = 1'b1;
        repeat (100) @(negedge clk);
        rst    = 1'b1;
        env_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({demod_bit, rx_byte, byte_valid, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 000", {demod_bit, rx_byte, byte_valid, frame_err, busy});
        end
        rst = 1'b0;
        busy_cnt = 0;
        repeat (BC) @(negedge clk);
        checks++;
        if (bv_cnt - bv0 + fe_cnt - fe0 + busy_cnt !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: valid %0d err %0d busy %0d want 0",
                     bv_cnt - bv0, fe_cnt - fe0, busy_cnt);
        end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (bv_cnt - bv0 !== 1 || rx_byte !== 8'h81) begin
            errors++;
            $display("FAIL midrst_next: got %h x%0d want 81 x1", rx_byte, bv_cnt - bv0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_bad_stop();
        test_noise();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
